// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle for riscv_mem_arbiter: instruction-fetch port, data port and the shared memory port.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface riscv_mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req;
    logic [DATA_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_err;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [3:0]            d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory port, one transaction in flight, with timeout.
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise the data port always wins.
module riscv_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 16
) (
    input  logic               clock,
    input  logic               reset,
    riscv_mem_arbiter_if.slave bus,
    output logic               busy
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam int unsigned     CntW    = 8;
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  owner_d_q, owner_d_d;  // 1: data port owns the transaction
    logic                  busy_q, busy_d;
    logic                  if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic                  if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic                  if_err_q, if_err_d, d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic                  pick_d;
    logic                  fin, fin_err;
    logic [DATA_WIDTH-1:0] fin_data;

`ifdef ARB_RR_EN
    logic prefer_d_q, prefer_d_d;

    always_comb begin
        pick_d     = bus.d_req & (~bus.if_req | prefer_d_q);
        prefer_d_d = prefer_d_q;
        if (state_q == StIdle && (bus.if_req || bus.d_req)) begin
            prefer_d_d = ~pick_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prefer_d_q <= 1'b1;
        end else begin
            prefer_d_q <= prefer_d_d;
        end
    end
`else
    always_comb begin
        pick_d = bus.d_req;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d_d   = owner_d_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_err_d     = 1'b0;
        if_rdata_d  = '0;
        d_rdata_d   = '0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        fin         = 1'b0;
        fin_err     = 1'b0;
        fin_data    = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.if_req || bus.d_req) begin
                    state_d   = StReq;
                    owner_d_d = pick_d;
                    mem_req_d = 1'b1;
                    if (pick_d) begin
                        d_gnt_d     = 1'b1;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_be_d    = bus.d_be;
                    end else begin
                        if_gnt_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = 4'hF;
                    end
                end
            end
            StReq: begin
                if (bus.mem_ready) begin
                    state_d   = StWait;
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            StWait: begin
                // A response on the last wait cycle still beats the timeout.
                if (bus.mem_rvalid) begin
                    fin      = 1'b1;
                    fin_data = mem_we_q ? '0 : bus.mem_rdata;
                end else if (cnt_q == CntLast) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (fin) begin
                    state_d = StResp;
                    if (owner_d_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = fin_data;
                        d_err_d    = fin_err;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = fin_data;
                        if_err_d    = fin_err;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            owner_d_q   <= 1'b0;
            busy_q      <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_d_q   <= owner_d_d;
            busy_q      <= busy_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_err_q    <= if_err_d;
            d_err_q     <= d_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign busy          = busy_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed table, hand sequences, random transactions.
// Expected winners and responses come from a transaction-level model of the arbitration rules.
module tb_riscv_mem_arbiter;
    localparam int MW = 16;

    typedef struct {
        logic        ir;
        logic        dr;
        logic        dwe;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        int          rdly;
        int          kdly;
        logic [31:0] mrd;
        logic        exp_d;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

`ifdef ARB_RR_EN
    localparam logic Exp6 = 1'b0;
    localparam logic [3:0] ExpSeq = 4'b0101;
`else
    localparam logic Exp6 = 1'b1;
    localparam logic [3:0] ExpSeq = 4'b1111;
`endif

    logic clock;
    logic reset;
    logic busy;
    int   total;
    int   bad;
    logic m_prefer_d;
    vec_t vecs[7];

    riscv_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

    riscv_mem_arbiter #(
        .DATA_WIDTH(32),
        .MAX_WAIT  (MW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic model_winner(input logic ir, input logic dr);
        if (ir && dr) begin
`ifdef ARB_RR_EN
            return m_prefer_d;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic chk_all_zero(input string name);
        chk(name, {62'(0), busy, bus.mem_req}, 64'd0);
        chk(name, {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err,
                   bus.mem_we, bus.mem_be}, 64'd0);
        chk(name, {bus.mem_addr, bus.mem_wdata}, 64'd0);
        chk(name, {bus.if_rdata, bus.d_rdata}, 64'd0);
    endtask

    // Drives one transaction from an idle negedge and checks it cycle by cycle.
    task automatic run_txn(input vec_t v);
        logic [31:0] ea;
        logic        ewe;
        logic [3:0]  ebe;
        logic        timeout;
        timeout        = (v.kdly >= MW);
        bus.if_req     = v.ir;
        bus.if_addr    = v.ia;
        bus.d_req      = v.dr;
        bus.d_we       = v.dwe;
        bus.d_addr     = v.da;
        bus.d_wdata    = v.dwd;
        bus.d_be       = v.dbe;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        step();
        ewe = v.exp_d & v.dwe;
        ea  = v.exp_d ? v.da : v.ia;
        ebe = v.exp_d ? v.dbe : 4'hF;
        chk("gnt", {62'(0), bus.d_gnt, bus.if_gnt}, {62'(0), v.exp_d, ~v.exp_d});
        chk("mem_req", {61'(0), busy, bus.mem_req, bus.mem_we}, {61'(0), 1'b1, 1'b1, ewe});
        chk("mem_addr", {32'(0), bus.mem_addr}, {32'(0), ea});
        chk("mem_be", {60'(0), bus.mem_be}, {60'(0), ebe});
        if (ewe) chk("mem_wdata", {32'(0), bus.mem_wdata}, {32'(0), v.dwd});
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b0;
        bus.if_addr = ~v.ia;
        bus.d_addr  = ~v.da;
        bus.d_wdata = ~v.dwd;
        bus.d_be    = ~v.dbe;
        bus.d_we    = ~v.dwe;
        for (int i = 0; i < v.rdly; i++) begin
            step();
            chk("req_hold", {60'(0), bus.mem_req, bus.mem_we, bus.d_gnt, bus.if_gnt},
                {60'(0), 1'b1, ewe, 2'b00});
            chk("field_hold", {28'(0), bus.mem_addr, bus.mem_be}, {28'(0), ea, ebe});
        end
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        for (int j = 0; j < MW; j++) begin
            chk("wait", {60'(0), busy, bus.mem_req, bus.if_rvalid, bus.d_rvalid}, 64'h8);
            if (j == v.kdly) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = v.mrd;
                step();
                bus.mem_rvalid = 1'b0;
                break;
            end
            bus.mem_rdata = $urandom;
            step();
        end
        chk("rvalid", {62'(0), bus.d_rvalid, bus.if_rvalid}, {62'(0), v.exp_d, ~v.exp_d});
        chk("rdata", {32'(0), (v.exp_d ? bus.d_rdata : bus.if_rdata)}, {32'(0), v.exp_rdata});
        chk("err", {63'(0), (v.exp_d ? bus.d_err : bus.if_err)}, {63'(0), v.exp_err});
        if (timeout) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hBAD0BAD0;
        end
        step();
        chk("idle", {58'(0), busy, bus.mem_req, bus.if_rvalid, bus.d_rvalid, bus.if_gnt,
                     bus.d_gnt}, 64'd0);
        bus.mem_rvalid = 1'b0;
        m_prefer_d     = ~v.exp_d;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset      = 1'b1;
        m_prefer_d = 1'b1;
    endtask

    initial begin
        clock          = 1'b0;
        reset          = 1'b0;
        total          = 0;
        bad            = 0;
        m_prefer_d     = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_be       = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF,
                    1'b1, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'h12345678, 4'b0011, 5, 1, 32'hAAAA5555,
                    1'b1, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 4'h0, 0, 99, 32'h55,
                    1'b0, 32'h0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h404, 32'h0, 32'h0, 4'h0, 1, 3, 32'h13,
                    1'b0, 32'h13, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h103, 32'h0, 4'h0, 2, MW - 1, 32'hCAFEF00D,
                    1'b1, 32'hCAFEF00D, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'hFFFF0000, 4'b1000, 0, 99, 32'h77,
                    1'b1, 32'h0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h500, 32'h600, 32'h0, 4'h0, 1, 2, 32'h600D600D,
                    Exp6, 32'h600D600D, 1'b0};

        #3;
        chk_all_zero("reset_state");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int n = 0; n < 7; n++) begin
            run_txn(vecs[n]);
        end

        // Four back-to-back simultaneous requests from a fresh reset.
        pulse_reset();
        begin
            logic [3:0] seq;
            seq = ExpSeq;
            for (int n = 0; n < 4; n++) begin
                vec_t v;
                v = '{1'b1, 1'b1, 1'b0, 32'h1000 + 32'(n * 4), 32'h2000 + 32'(n * 4), 32'h0,
                      4'h0, 0, 0, 32'h100 + 32'(n), seq[n], 32'h100 + 32'(n), 1'b0};
                run_txn(v);
            end
        end

        // Reset while waiting for the memory: silent abandon, then normal service.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h800;
        step();
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        step();
        chk("pre_reset_wait", {62'(0), busy, bus.mem_req}, 64'h2);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("reset_in_wait");
        @(negedge clock);
        reset          = 1'b1;
        m_prefer_d     = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12121212;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_reset_quiet", {60'(0), busy, bus.mem_req, bus.if_rvalid, bus.d_rvalid},
                64'd0);
        end
        bus.mem_rvalid = 1'b0;
        begin
            vec_t v;
            v = '{1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h0, 4'h0, 0, 0, 32'h31415926,
                  1'b0, 32'h31415926, 1'b0};
            run_txn(v);
        end

        for (int n = 0; n < 40; n++) begin
            vec_t v;
            int   sel;
            sel    = int'($urandom_range(1, 3));
            v.ir   = sel[0];
            v.dr   = sel[1];
            v.dwe  = 1'($urandom_range(0, 1));
            v.ia   = $urandom & ~32'h3;
            v.da   = $urandom;
            v.dwd  = $urandom;
            v.dbe  = 4'($urandom_range(0, 15));
            v.rdly = int'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) v.kdly = MW + int'($urandom_range(0, 3));
            else v.kdly = int'($urandom_range(0, MW - 1));
            v.mrd       = $urandom;
            v.exp_d     = model_winner(v.ir, v.dr);
            v.exp_err   = (v.kdly >= MW);
            v.exp_rdata = (v.exp_err || (v.exp_d && v.dwe)) ? 32'h0 : v.mrd;
            run_txn(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
